// File: rtl/peak_detect.sv
// Per-frame spectral peak search: reports bin index, magnitude and phase of the largest bin.
// Optional PEAK_DETECT_THRESHOLD_EN adds sink_threshold / source_nopeak.
module peak_detect #(
   parameter int unsigned WIDTH  = 25,
   parameter int unsigned LENGTH = 2048,
   parameter int unsigned MINBIN = 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      sink_valid,
   input  logic                      sink_sop,
   input  logic                      sink_eop,
   input  logic [WIDTH-1:0]          sink_mag,
   input  logic [15:0]               sink_phase,
`ifdef PEAK_DETECT_THRESHOLD_EN
   input  logic [WIDTH-1:0]          sink_threshold,
   output logic                      source_nopeak,
`endif
   output logic                      source_valid,
   output logic [$clog2(LENGTH)-1:0] source_bin,
   output logic [WIDTH-1:0]          source_mag,
   output logic [15:0]               source_phase,
   output logic                      source_error
);

   localparam int unsigned CntW = $clog2(LENGTH);
   localparam logic [CntW-1:0] LastBin = CntW'(LENGTH - 1);
   localparam logic [CntW-1:0] HalfBin = CntW'(LENGTH / 2);
   localparam logic [CntW-1:0] MinBin  = CntW'(MINBIN);

   typedef enum logic [1:0] {StIdle, StFrame, StEmit} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              best_vld_q, best_vld_d;
   logic [CntW-1:0]   best_bin_q, best_bin_d;
   logic [WIDTH-1:0]  best_mag_q, best_mag_d;
   logic [15:0]       best_phase_q, best_phase_d;
   logic              valid_q, valid_d;
   logic              error_q, error_d;
   logic [CntW-1:0]   out_bin_q, out_bin_d;
   logic [WIDTH-1:0]  out_mag_q, out_mag_d;
   logic [15:0]       out_phase_q, out_phase_d;
   logic              nopeak_q, nopeak_d;
   logic              take, start, in_range;
   logic [CntW-1:0]   idx;
   logic [WIDTH-1:0]  thr;

`ifdef PEAK_DETECT_THRESHOLD_EN
   assign thr           = sink_threshold;
   assign source_nopeak = nopeak_q;
`else
   assign thr = '0;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      best_vld_d   = best_vld_q;
      best_bin_d   = best_bin_q;
      best_mag_d   = best_mag_q;
      best_phase_d = best_phase_q;
      valid_d      = 1'b0;
      error_d      = 1'b0;
      nopeak_d     = 1'b0;
      out_bin_d    = out_bin_q;
      out_mag_d    = out_mag_q;
      out_phase_d  = out_phase_q;
      take         = 1'b0;
      start        = 1'b0;

      unique case (state_q)
         StIdle, StEmit: begin
            if (sink_valid && sink_sop) begin
               take  = 1'b1;
               start = 1'b1;
            end
         end
         StFrame: begin
            if (sink_valid) begin
               take = 1'b1;
               // sop inside a frame aborts it and restarts on this very beat
               if (sink_sop) begin
                  start   = 1'b1;
                  error_d = 1'b1;
               end
            end
         end
         default: ;
      endcase

      idx      = start ? '0 : cnt_q;
      in_range = (idx >= MinBin) && (idx < HalfBin);

      if (take) begin
         state_d    = StFrame;
         cnt_d      = idx + CntW'(1);
         best_vld_d = start ? 1'b0 : best_vld_q;
         if (in_range && (!best_vld_d || sink_mag > best_mag_q)) begin
            best_vld_d   = 1'b1;
            best_bin_d   = idx;
            best_mag_d   = sink_mag;
            best_phase_d = sink_phase;
         end
         if (idx == LastBin && sink_eop) begin
            state_d     = StEmit;
            cnt_d       = '0;
            valid_d     = 1'b1;
            nopeak_d    = best_mag_d < thr;
            out_bin_d   = best_bin_d;
            out_mag_d   = best_mag_d;
            out_phase_d = best_phase_d;
         end else if (idx == LastBin || sink_eop) begin
            state_d = StIdle;
            cnt_d   = '0;
            error_d = 1'b1;
         end
      end else if (state_q == StEmit) begin
         state_d = StIdle;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         best_vld_q   <= 1'b0;
         best_bin_q   <= '0;
         best_mag_q   <= '0;
         best_phase_q <= '0;
         valid_q      <= 1'b0;
         error_q      <= 1'b0;
         nopeak_q     <= 1'b0;
         out_bin_q    <= '0;
         out_mag_q    <= '0;
         out_phase_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         best_vld_q   <= best_vld_d;
         best_bin_q   <= best_bin_d;
         best_mag_q   <= best_mag_d;
         best_phase_q <= best_phase_d;
         valid_q      <= valid_d;
         error_q      <= error_d;
         nopeak_q     <= nopeak_d;
         out_bin_q    <= out_bin_d;
         out_mag_q    <= out_mag_d;
         out_phase_q  <= out_phase_d;
      end
   end

   assign source_valid = valid_q;
   assign source_error = error_q;
   assign source_bin   = out_bin_q;
   assign source_mag   = out_mag_q;
   assign source_phase = out_phase_q;

endmodule

// File: tb/tb_peak_detect.sv
// Directed plus randomized frames for peak_detect (LENGTH=16, MINBIN=1), checked against a
// frame-level reference model.
module tb_peak_detect;
   localparam int W  = 25;
   localparam int L  = 16;
   localparam int MB = 1;
   localparam int BW = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          sink_valid, sink_sop, sink_eop;
   logic [W-1:0]  sink_mag;
   logic [15:0]   sink_phase;
   logic          source_valid, source_error;
   logic [BW-1:0] source_bin;
   logic [W-1:0]  source_mag;
   logic [15:0]   source_phase;
   logic [W-1:0]  thr;
`ifdef PEAK_DETECT_THRESHOLD_EN
   logic          source_nopeak;
`endif

   int vectors = 0;
   int miscompares = 0;

   logic [BW-1:0] exp_bin;
   logic [W-1:0]  exp_mag;
   logic [15:0]   exp_phase;
   int unsigned   fm[L];
   int unsigned   fp[L];

   always #5 clk = ~clk;

   peak_detect #(.WIDTH(W), .LENGTH(L), .MINBIN(MB)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .sink_valid     (sink_valid),
      .sink_sop       (sink_sop),
      .sink_eop       (sink_eop),
      .sink_mag       (sink_mag),
      .sink_phase     (sink_phase),
`ifdef PEAK_DETECT_THRESHOLD_EN
      .sink_threshold (thr),
      .source_nopeak  (source_nopeak),
`endif
      .source_valid   (source_valid),
      .source_bin     (source_bin),
      .source_mag     (source_mag),
      .source_phase   (source_phase),
      .source_error   (source_error)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic chk_held(input string tag);
      chk({tag, "_bin"}, 64'(source_bin), 64'(exp_bin));
      chk({tag, "_mag"}, 64'(source_mag), 64'(exp_mag));
      chk({tag, "_phase"}, 64'(source_phase), 64'(exp_phase));
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_valid"}, 64'(source_valid), 64'd0);
      chk({tag, "_error"}, 64'(source_error), 64'd0);
`ifdef PEAK_DETECT_THRESHOLD_EN
      chk({tag, "_nopeak"}, 64'(source_nopeak), 64'd0);
`endif
      chk_held(tag);
   endtask

   task automatic check_err(input string tag);
      chk({tag, "_valid"}, 64'(source_valid), 64'd0);
      chk({tag, "_error"}, 64'(source_error), 64'd1);
      chk_held(tag);
   endtask

   // Reference: first in-range bin loads, later bins replace only when strictly larger
   task automatic model_peak();
      bit          found = 1'b0;
      int unsigned best = 0;
      for (int i = MB; i < L / 2; i++) begin
         if (!found || fm[i] > best) begin
            found     = 1'b1;
            best      = fm[i];
            exp_bin   = BW'(i);
            exp_phase = fp[i][15:0];
         end
      end
      exp_mag = best[W-1:0];
   endtask

   task automatic beat(input logic sop, input logic eop, input logic [W-1:0] m,
                       input logic [15:0] p);
      sink_valid = 1'b1;
      sink_sop   = sop;
      sink_eop   = eop;
      sink_mag   = m;
      sink_phase = p;
      @(posedge clk);
      #1;
      sink_valid = 1'b0;
      sink_sop   = 1'b0;
      sink_eop   = 1'b0;
      sink_mag   = '0;
      sink_phase = '0;
   endtask

   // gap_mode: 0 contiguous, 1 idle cycle before every beat, 2 random idle cycles
   task automatic send_bins(input int last_bin, input int eop_bin, input int gap_mode,
                            input bit sop_err, input string tag);
      for (int i = 0; i <= last_bin; i++) begin
         if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
            @(posedge clk);
            #1;
            check_quiet({tag, "_gap"});
         end
         beat(i == 0, i == eop_bin, fm[i][W-1:0], fp[i][15:0]);
         if (i == 0 && sop_err) begin
            check_err({tag, "_soperr"});
         end else if (i == eop_bin && i == L - 1) begin
            model_peak();
            chk({tag, "_valid"}, 64'(source_valid), 64'd1);
            chk({tag, "_error"}, 64'(source_error), 64'd0);
            chk_held(tag);
`ifdef PEAK_DETECT_THRESHOLD_EN
            chk({tag, "_nopeak"}, 64'(source_nopeak), 64'(exp_mag < thr));
`endif
         end else if (i == eop_bin || i == L - 1) begin
            check_err({tag, "_framing"});
         end else begin
            check_quiet({tag, "_beat"});
         end
      end
   endtask

   task automatic fill_ramp();
      for (int i = 0; i < L; i++) begin
         fm[i] = i * 10;
         fp[i] = i * 256;
      end
      fm[5] = 500;
   endtask

   task automatic fill_random(input bit narrow);
      for (int i = 0; i < L; i++) begin
         fm[i] = narrow ? $urandom_range(0, 3) : $urandom_range(0, (1 << W) - 1);
         fp[i] = $urandom_range(0, 65535);
      end
   endtask

   initial begin
      reset_n    = 1'b0;
      sink_valid = 1'b0;
      sink_sop   = 1'b0;
      sink_eop   = 1'b0;
      sink_mag   = '0;
      sink_phase = '0;
      thr        = '0;
      exp_bin    = '0;
      exp_mag    = '0;
      exp_phase  = '0;
      #3;
      check_quiet("reset");
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // beats without sop while idle are dropped
      for (int i = 0; i < 3; i++) begin
         beat(1'b0, i == 2, W'($urandom_range(0, 1000)), 16'(i));
         check_quiet("idle_nosop");
      end

      fill_ramp();
      send_bins(L - 1, L - 1, 0, 1'b0, "ramp");
      chk("ramp_bin_abs", 64'(source_bin), 64'd5);
      chk("ramp_mag_abs", 64'(source_mag), 64'd500);
      chk("ramp_phase_abs", 64'(source_phase), 64'd1280);

      // back-to-back: sop arrives while the previous result is being emitted
      for (int i = 0; i < L; i++) begin
         fm[i] = 0;
         fp[i] = 100 + i;
      end
      fm[3]  = 900;
      fm[6]  = 900;
      fm[0]  = 9999;
      fm[12] = 9999;
      send_bins(L - 1, L - 1, 0, 1'b0, "tie");
      chk("tie_bin_abs", 64'(source_bin), 64'd3);
      chk("tie_mag_abs", 64'(source_mag), 64'd900);
      @(posedge clk);
      #1;
      check_quiet("tie_after");

      fill_ramp();
      send_bins(L - 1, L - 1, 1, 1'b0, "gapped");
      chk("gapped_bin_abs", 64'(source_bin), 64'd5);

      fill_random(1'b0);
      send_bins(9, 9, 0, 1'b0, "eop9");
      @(posedge clk);
      #1;
      check_quiet("eop9_after");

      send_bins(6, -1, 0, 1'b0, "pre_sop7");
      fill_random(1'b0);
      send_bins(L - 1, L - 1, 0, 1'b1, "sop7");

      fill_random(1'b0);
      send_bins(L - 1, -1, 0, 1'b0, "noeop");
      @(posedge clk);
      #1;
      check_quiet("noeop_after");

      // asynchronous reset mid-frame, asserted between clock edges
      fill_random(1'b0);
      send_bins(7, -1, 0, 1'b0, "prereset");
      #2 reset_n = 1'b0;
      #1;
      exp_bin   = '0;
      exp_mag   = '0;
      exp_phase = '0;
      check_quiet("async_reset");
      @(posedge clk);
      #1 reset_n = 1'b1;
      for (int i = 8; i < L; i++) begin
         beat(1'b0, i == L - 1, fm[i][W-1:0], fp[i][15:0]);
         check_quiet("post_reset_tail");
      end
      fill_random(1'b0);
      send_bins(L - 1, L - 1, 0, 1'b0, "post_reset");

      for (int f = 0; f < 20; f++) begin
         fill_random($urandom_range(0, 2) == 0);
         thr = W'($urandom_range(0, (1 << W) - 1));
         send_bins(L - 1, L - 1, $urandom_range(0, 2), 1'b0, "rand");
      end

`ifdef PEAK_DETECT_THRESHOLD_EN
      thr = W'(1000);
      fill_ramp();
      send_bins(L - 1, L - 1, 0, 1'b0, "thr500");
      chk("thr500_nopeak_abs", 64'(source_nopeak), 64'd1);
      fm[5] = 1000;
      send_bins(L - 1, L - 1, 0, 1'b0, "thr1000");
      chk("thr1000_nopeak_abs", 64'(source_nopeak), 64'd0);
`endif

      @(posedge clk);
      #1;
      check_quiet("final");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
